load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Load-path formatter between the LSU address stage and writeback; successor of the fixed word/byte load-data mux.
- Accepts one load request (address, size, signedness, dest tag) and issues word-aligned reads to data memory.
- Extracts the addressed byte, halfword or word and zero- or sign-extends it to DATA_W.
- Returns the result over a valid/ready handshake; a word-crossing access can be served with two reads.

Parameters:
- DATA_W, 32, memory word and result width; 32 or 64 only.
- ADDR_W, 32, byte-address width.
- TAG_W, 5, destination-register tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  unit idle; can accept a request
- req_addr  in  ADDR_W  byte address
- req_size  in  2  log2 of the access size in bytes: 0=byte, 1=half, 2=word, 3=dword (dword legal only when DATA_W=64)
- req_signed  in  1  1=sign-extend, 0=zero-extend
- req_tag  in  TAG_W  destination tag
- mem_req  out  1  read request, held until mem_rvalid
- mem_addr  out  ADDR_W  word-aligned read address (low log2(DATA_W/8) bits zero)
- mem_rvalid  in  1  read data valid; one pulse per mem_req
- mem_rdata  in  DATA_W  read word
- resp_valid  out  1  result valid
- resp_ready  in  1  writeback accepts the result
- resp_data  out  DATA_W  aligned, extended result
- resp_tag  out  TAG_W  tag of the result
- resp_err  out  1  illegal size, or a misaligned access when splitting is compiled out

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE. Outputs are req_ready=1, mem_req=0, mem_addr=0, resp_valid=0, resp_data=0, resp_tag=0, resp_err=0.
- Reset mid-operation abandons the access. Any mem_rvalid arriving after reset while in IDLE is ignored.
- FSM states: IDLE, RD0, RD1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/size/signed/tag.
  - Illegal size goes to RESP with resp_err=1 and resp_data=0; no memory access is made.
  - Otherwise go to RD0 with mem_addr = addr with its low bits cleared.
- RD0:
  - mem_req=1.
  - On mem_rvalid, capture the word into lo_buf.
  - If (offset + 2^size) > DATA_W/8, the access crosses a word boundary: go to RD1 with mem_addr += DATA_W/8. Wrap-around modulo 2^ADDR_W is permitted.
  - Otherwise go to RESP.
- RD1:
  - mem_req=1.
  - On mem_rvalid, form {rdata, lo_buf} and shift right by offset*8.
  - Go to RESP.
- mem_req deasserts in the same cycle the FSM leaves RD0 or RD1, so at most one request is outstanding.
- Extraction: field = (buffer >> offset*8) masked to 8<<size bits.
  - When req_signed=1, the field's MSB is replicated to DATA_W; otherwise the upper bits are zero.
  - A word load on DATA_W=32 is passed through unmodified. A byte load with req_signed=0 reproduces the legacy load-byte behaviour.
- RESP:
  - resp_valid=1; data, tag and err are registered and held stable while resp_ready=0.
  - On resp_ready, go to IDLE.
  - A new request can be accepted in the cycle after the handshake; no back-to-back overlap.
- Latency: aligned access = memory latency + 1 cycle to resp_valid. Split access = two memory latencies + 1.
- req_valid while req_ready=0 is ignored; the requester holds it.
- mem_rvalid in IDLE or RESP is ignored.

Optional Feature:
- Macro: LD_MISALIGN_SPLIT_EN.
- Defined: word-crossing accesses use RD1 as described above.
- Undefined: RD1 is not implemented.
  - Any access whose offset is not a multiple of 2^size goes directly IDLE->RESP with resp_err=1, resp_data=0 and no mem_req.
  - Naturally aligned accesses behave identically to the defined case.

Decomposition:
- Shared package (lsu_pkg) holds:
  - size encoding constants: LD_BYTE=0, LD_HALF=1, LD_WORD=2, LD_DWORD=3;
  - the FSM state enum;
  - function size_bytes(size).
- One sub-module, ld_extend: combinational shift, mask and sign/zero extension.
  - Inputs: buffer of 2*DATA_W bits, offset, size, signed.
  - Output: DATA_W-bit result.
  - Reused later by the store-data path check.

Test Plan:
- DATA_W=32, addr=0x103, size=0, signed=1, mem word 0x80FF_1234 -> resp_data=0xFFFF_FF80, one mem_req at 0x100.
- Same access with signed=0 -> resp_data=0x0000_0080. Word load at addr 0x100 -> 0x80FF_1234 unchanged.
- Split defined: addr=0x102, size=2, words 0xAABB_CCDD @0x100 and 0x1122_3344 @0x104 -> mem_addr 0x100 then 0x104, resp_data=0x3344_AABB, resp_err=0.
- Split undefined: same request -> resp_err=1, resp_data=0, no mem_req. size=3 on DATA_W=32 -> resp_err=1 in both builds.
- Hold resp_ready=0 for 5 cycles -> resp_valid, resp_data and resp_tag stable and req_ready=0. Then resp_ready=1 -> IDLE next cycle.
- Assert rst_n=0 during RD1 -> next cycle all outputs at reset values. A late mem_rvalid is ignored, and the next request completes correctly.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU load-path types: size encodings, FSM state, size helper.
// Imported by load_align_unit and ld_extend.
package lsu_pkg;

  localparam logic [1:0] LD_BYTE  = 2'd0;
  localparam logic [1:0] LD_HALF  = 2'd1;
  localparam logic [1:0] LD_WORD  = 2'd2;
  localparam logic [1:0] LD_DWORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RD0,
    RD1,
    RESP
  } ld_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ld_extend.sv
// Load-data extractor: shifts a two-word buffer right by offset bytes,
// masks to the access size and zero/sign-extends to DATA_W.
// Ports: data_buf (2*DATA_W), offset, size, sgn -> result (DATA_W).
module ld_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [2*DATA_W-1:0] data_buf,
  input  logic [OFF_W-1:0]    offset,
  input  logic [1:0]          size,
  input  logic                sgn,
  output logic [DATA_W-1:0]   result
);

  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] mask;
  logic              msb;

  always_comb begin
    lo   = DATA_W'(data_buf >> {offset, 3'b000});
    mask = '1;
    msb  = 1'b0;
    unique case (size)
      LD_BYTE: begin
        mask = DATA_W'(8'hff);
        msb  = lo[7];
      end
      LD_HALF: begin
        mask = DATA_W'(16'hffff);
        msb  = lo[15];
      end
      LD_WORD: begin
        mask = DATA_W'({32{1'b1}});
        msb  = lo[31];
      end
      default: begin
        mask = '1;
        msb  = lo[DATA_W-1];
      end
    endcase
    result = (sgn && msb) ? (lo | ~mask)
                          : (lo & mask);
  end

endmodule

// File: rtl/load_align_unit.sv
// Load-path formatter: word-aligned memory reads, byte/half/word
// extraction and extension, valid/ready result handshake.
// Ports: req_* (request in), mem_* (data memory), resp_* (result out).
// Macro LD_MISALIGN_SPLIT_EN: serve word-crossing loads with two reads;
// when undefined, misaligned loads return resp_err without memory access.
module load_align_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  ld_state_e state;

  logic [OFF_W-1:0]    off_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic [OFF_W-1:0]    req_off;
  logic                size_bad;
  logic                reject;
  logic [ADDR_W-1:0]   word_mask;
  logic [2*DATA_W-1:0] ext_buf;
  logic [DATA_W-1:0]   ext_data;

  assign req_off   = req_addr[OFF_W-1:0];
  assign size_bad  = (req_size == LD_DWORD)
                  && (DATA_W == 32);
  assign word_mask = {ADDR_W{1'b1}} << OFF_W;

`ifdef LD_MISALIGN_SPLIT_EN
  logic [DATA_W-1:0] lo_buf;
  logic              crosses;

  assign reject  = size_bad;
  assign crosses = (5'(off_q) + 5'(size_bytes(size_q)))
                 > 5'(BYTES);
`else
  logic mis;

  // offset not a multiple of the access size
  assign mis    = |(req_off
                  & OFF_W'(size_bytes(req_size) - 4'd1));
  assign reject = size_bad || mis;
`endif

  always_comb begin
    ext_buf = {{DATA_W{1'b0}}, mem_rdata};
`ifdef LD_MISALIGN_SPLIT_EN
    if (state == RD1)
      ext_buf = {mem_rdata, lo_buf};
`endif
  end

  ld_extend #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_ext (
    .data_buf (ext_buf),
    .offset   (off_q),
    .size     (size_q),
    .sgn      (sgn_q),
    .result   (ext_data)
  );

  assign req_ready  = (state == IDLE);
  assign mem_req    = (state == RD0)
                   || (state == RD1);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      resp_data <= '0;
      resp_tag  <= '0;
      resp_err  <= 1'b0;
      off_q     <= '0;
      size_q    <= LD_BYTE;
      sgn_q     <= 1'b0;
`ifdef LD_MISALIGN_SPLIT_EN
      lo_buf    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            off_q     <= req_off;
            size_q    <= req_size;
            sgn_q     <= req_signed;
            resp_tag  <= req_tag;
            resp_data <= '0;
            if (reject) begin
              resp_err <= 1'b1;
              state    <= RESP;
            end else begin
              resp_err <= 1'b0;
              mem_addr <= req_addr & word_mask;
              state    <= RD0;
            end
          end
        end
        RD0: begin
          if (mem_rvalid) begin
`ifdef LD_MISALIGN_SPLIT_EN
            lo_buf <= mem_rdata;
            if (crosses) begin
              mem_addr <= mem_addr
                        + ADDR_W'(BYTES);
              state    <= RD1;
            end else begin
              resp_data <= ext_data;
              state     <= RESP;
            end
`else
            resp_data <= ext_data;
            state     <= RESP;
`endif
          end
        end
        RD1: begin
`ifdef LD_MISALIGN_SPLIT_EN
          if (mem_rvalid) begin
            resp_data <= ext_data;
            state     <= RESP;
          end
`else
          state <= IDLE;
`endif
        end
        RESP: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed loads with
// hand-computed results, memory responder and response monitor.
module tb_load_align_unit;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 5;

`ifdef LD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = '0;
  logic          req_signed = 1'b0;
  logic [TW-1:0] req_tag = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic          resp_err;

  load_align_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .TAG_W  (TW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_tag    (req_tag),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          e;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];

  int            errors = 0;
  int            checks = 0;
  int            mem_lat = 0;
  logic [AW-1:0] hold_addr = '1;
  int            resp_cnt = 0;
  int            mreq_cyc = 0;

  function automatic logic [DW-1:0] mem_rd(
    input logic [AW-1:0] a);
    case (a)
      32'h100: return 32'h80FF_1234;
      32'h104: return 32'h1122_3344;
      32'h200: return 32'hAABB_CCDD;
      32'h204: return 32'h1122_3344;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // memory responder
  initial begin
    logic [AW-1:0] a;
    forever begin
      if (mem_req && rst_n && mem_addr != hold_addr) begin
        a = mem_addr;
        if (addr_q.size() == 0) begin
          check("mem_addr_unexpected", a, 0);
        end else begin
          check("mem_addr", a, addr_q.pop_front());
        end
        repeat (mem_lat) @(negedge clk);
        mem_rdata  = mem_rd(a);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  // response monitor
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (mem_req) mreq_cyc++;
      if (rst_n && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", resp_valid, 0);
        end else begin
          x = exp_q.pop_front();
          check("resp_data", resp_data, x.d);
          check("resp_tag", resp_tag, x.t);
          check("resp_err", resp_err, x.e);
        end
        resp_cnt++;
      end
    end
  end

  task automatic wait_ready();
    int cyc = 0;
    while (!req_ready && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("req_ready_timeout", req_ready, 1);
  endtask

  task automatic issue(input logic [AW-1:0] a,
                       input logic [1:0]    sz,
                       input logic          sg,
                       input logic [TW-1:0] tg,
                       input logic [DW-1:0] ed,
                       input logic          ee,
                       input int            na,
                       input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1);
    int c0;
    int m0;
    int cyc;
    wait_ready();
    if (na > 0) addr_q.push_back(a0);
    if (na > 1) addr_q.push_back(a1);
    exp_q.push_back('{d: ed, t: tg, e: ee});
    c0 = resp_cnt;
    m0 = mreq_cyc;
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_tag    = tg;
    step(1);
    req_valid = 1'b0;
    cyc = 0;
    while (resp_cnt == c0 && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("resp_timeout", resp_cnt - c0, 1);
    if (na == 0)
      check("no_mem_req", mreq_cyc - m0, 0);
    check("mem_reads_done", addr_q.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_resp_tag"}, resp_tag, 0);
    check({tag, "_resp_err"}, resp_err, 0);
  endtask

  initial begin
    int cyc;
    step(3);
    check_reset_outs("rst");
    rst_n = 1'b1;
    step(1);

    mem_lat = 0;
    issue(32'h103, 2'd0, 1, 5'd1, 32'hFFFF_FF80,
          0, 1, 32'h100, 0);
    mem_lat = 1;
    issue(32'h103, 2'd0, 0, 5'd2, 32'h0000_0080,
          0, 1, 32'h100, 0);
    mem_lat = 2;
    issue(32'h100, 2'd2, 1, 5'd3, 32'h80FF_1234,
          0, 1, 32'h100, 0);
    mem_lat = 0;
    issue(32'h102, 2'd1, 1, 5'd4, 32'hFFFF_80FF,
          0, 1, 32'h100, 0);
    issue(32'h102, 2'd1, 0, 5'd5, 32'h0000_80FF,
          0, 1, 32'h100, 0);
    issue(32'h101, 2'd0, 1, 5'd6, 32'h0000_0012,
          0, 1, 32'h100, 0);
    issue(32'h100, 2'd1, 1, 5'd7, 32'h0000_1234,
          0, 1, 32'h100, 0);
    issue(32'h203, 2'd0, 0, 5'd8, 32'h0000_00AA,
          0, 1, 32'h200, 0);
    issue(32'h100, 2'd3, 0, 5'd9, 32'h0, 1, 0, 0, 0);

    mem_lat = 1;
    if (SPLIT) begin
      issue(32'h202, 2'd2, 0, 5'd10, 32'h3344_AABB,
            0, 2, 32'h200, 32'h204);
      issue(32'h203, 2'd1, 1, 5'd11, 32'h0000_44AA,
            0, 2, 32'h200, 32'h204);
      issue(32'h201, 2'd1, 1, 5'd12, 32'hFFFF_BBCC,
            0, 1, 32'h200, 0);
    end else begin
      issue(32'h202, 2'd2, 0, 5'd10, 32'h0, 1, 0, 0, 0);
      issue(32'h203, 2'd1, 1, 5'd11, 32'h0, 1, 0, 0, 0);
      issue(32'h201, 2'd1, 1, 5'd12, 32'h0, 1, 0, 0, 0);
    end

    // backpressure: result held stable
    mem_lat = 0;
    resp_ready = 1'b0;
    wait_ready();
    addr_q.push_back(32'h100);
    exp_q.push_back('{d: 32'h80, t: 5'h1E, e: 1'b0});
    req_valid  = 1'b1;
    req_addr   = 32'h103;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_tag    = 5'h1E;
    step(1);
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("hold_resp_timeout", resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, 32'h80);
      check("hold_tag", resp_tag, 5'h1E);
      check("hold_req_ready", req_ready, 0);
      step(1);
    end
    resp_ready = 1'b1;
    step(1);
    check("hold_release_idle", req_ready, 1);
    check("hold_release_valid", resp_valid, 0);
    check("hold_popped", exp_q.size(), 0);

    // reset while waiting on a read
    if (SPLIT) begin
      hold_addr = 32'h204;
      addr_q.push_back(32'h200);
      req_addr  = 32'h202;
    end else begin
      hold_addr = 32'h200;
      req_addr  = 32'h200;
    end
    req_valid  = 1'b1;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_tag    = 5'd7;
    step(1);
    req_valid = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_addr == hold_addr)
           && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("abort_stall_addr", mem_addr, hold_addr);
    step(2);
    rst_n = 1'b0;
    step(1);
    check_reset_outs("abort");
    rst_n = 1'b1;
    hold_addr = '1;
    step(1);
    mem_rdata  = 32'h5555_5555;
    mem_rvalid = 1'b1;
    step(1);
    mem_rvalid = 1'b0;
    step(1);
    check("late_rvalid_ready", req_ready, 1);
    check("late_rvalid_mem_req", mem_req, 0);
    check("late_rvalid_resp", resp_valid, 0);
    issue(32'h103, 2'd0, 1, 5'd13, 32'hFFFF_FF80,
          0, 1, 32'h100, 0);

    step(2);
    check("exp_q_empty", exp_q.size(), 0);
    check("addr_q_empty", addr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
